// File: rtl/noise_arbiter.sv
// ============================================================================
//  Module      : noise_arbiter
//  Description : Round-robin sharing of one LFSR noise generator between voices;
//                steps the generator after every grant and waits for it to settle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module noise_arbiter #(
    parameter int NUM_VOICES    = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_VOICES-1:0]   req,
    input  logic [4*NUM_VOICES-1:0] level,
    input  logic [143:0]            taps,
    output logic [NUM_VOICES-1:0]   ack,
    output logic [15:0]             noise_out,
    output logic [2:0]              noise_voice,
    output logic                    noise_valid,
    output logic                    lfsr_step
);

    localparam int c_CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic [2:0]            r_rr_ptr;
    logic [NUM_VOICES-1:0] r_ack;
    logic [15:0]           r_noise_out;
    logic [2:0]            r_noise_voice;
    logic                  r_noise_valid;
    logic                  r_lfsr_step;

    logic                  w_step_nxt;
    logic                  w_grant;
    logic                  w_found;
    logic [2:0]            w_win;
    logic [2:0]            w_next_ptr;
    logic [3:0]            w_idx;
    logic [7:0]            w_req_ext;
    logic [31:0]           w_level_ext;
    logic [3:0]            w_lvl;
    logic [3:0]            w_tap_idx;
    logic [15:0]           w_sample;

    // Zero-extend to the 8-voice maximum so absent voices can never win.
    always_comb begin
        w_req_ext                       = '0;
        w_req_ext[NUM_VOICES-1:0]       = req;
        w_level_ext                     = '0;
        w_level_ext[4*NUM_VOICES-1:0]   = level;
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(i);
            if (w_idx >= 4'(NUM_VOICES)) begin
                w_idx = w_idx - 4'(NUM_VOICES);
            end
            if (!w_found && w_req_ext[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
        w_next_ptr = (w_win == 3'(NUM_VOICES - 1)) ? 3'd0 : w_win + 3'd1;
    end

    // Level 15 mutes; 9..14 clamp to the top tap.
    always_comb begin
        w_lvl     = w_level_ext[{w_win, 2'b00} +: 4];
        w_tap_idx = (w_lvl > 4'd8) ? 4'd8 : w_lvl;
        w_sample  = '0;
        for (int k = 0; k < 9; k++) begin
            if (w_tap_idx == 4'(k)) begin
                w_sample = taps[16*k +: 16];
            end
        end
        if (w_lvl == 4'd15) begin
            w_sample = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_step_nxt = 1'b1;
                if (SETTLE_CYCLES == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = c_CW'(SETTLE_CYCLES);
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt - c_CW'(1);
                if (r_cnt <= c_CW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_ack         <= '0;
            r_noise_out   <= '0;
            r_noise_voice <= '0;
            r_noise_valid <= 1'b0;
            r_lfsr_step   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_lfsr_step   <= w_step_nxt;
            r_noise_valid <= w_grant;
            r_ack         <= w_grant ? (NUM_VOICES'(1) << w_win) : '0;
            if (w_grant) begin
                r_noise_out   <= w_sample;
                r_noise_voice <= w_win;
                r_rr_ptr      <= w_next_ptr;
            end
        end
    end

    assign ack         = r_ack;
    assign noise_out   = r_noise_out;
    assign noise_voice = r_noise_voice;
    assign noise_valid = r_noise_valid;
    assign lfsr_step   = r_lfsr_step;

endmodule

`default_nettype wire
